// File: rtl/modular_exponentiator_if.sv
// Requester/responder bus between the exponentiator and an external start/done
// modular multiplier computing P = X*Y mod M.
interface modular_exponentiator_if #(
  parameter int N = 1024
);
  logic [N-1:0] mul_x;
  logic [N-1:0] mul_y;
  logic [N-1:0] mul_m;
  logic         mul_start;
  logic [N-1:0] mul_p;
  logic         mul_done;

  modport master (
    output mul_x,
    output mul_y,
    output mul_m,
    output mul_start,
    input  mul_p,
    input  mul_done
  );

  modport slave (
    input  mul_x,
    input  mul_y,
    input  mul_m,
    input  mul_start,
    output mul_p,
    output mul_done
  );
endinterface

// File: rtl/modular_exponentiator.sv
// Left-to-right square-and-multiply controller computing R = B^E mod M,
// delegating every modular product to an external start/done multiplier.
//
// state     | meaning
// IDLE      | wait for start, latch B/E/M
// SCAN      | skip leading zero bits of E, one bit per cycle
// SQR_ISSUE | present R*R to the multiplier, raise mul_start
// SQR_WAIT  | wait for a fresh mul_done, take the square
// MUL_ISSUE | present R*B to the multiplier, raise mul_start
// MUL_WAIT  | wait for a fresh mul_done, take the product
// NEXT      | step to the next lower exponent bit or finish
// DONE      | result valid, hold R until start
module modular_exponentiator #(
  parameter int n = 1024
) (
  input  logic                 clk,
  input  logic                 n_reset,
  input  logic                 start,
  input  logic [n-1:0]         B,
  input  logic [n-1:0]         E,
  input  logic [n-1:0]         M,
  output logic [n-1:0]         R,
  output logic                 done,
  modular_exponentiator_if.master mul
);

  localparam int IW = (n > 1) ? $clog2(n) : 1;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    SQR_ISSUE,
    SQR_WAIT,
    MUL_ISSUE,
    MUL_WAIT,
    NEXT,
    DONE
  } state_t;

  state_t          state_q;
  logic [IW-1:0]   idx_q;
  logic [n-1:0]    b_q;
  logic [n-1:0]    e_q;
  logic [n-1:0]    m_q;
  logic [n-1:0]    r_q;
  logic            done_q;
  logic [n-1:0]    mul_x_q;
  logic [n-1:0]    mul_y_q;
  logic            mul_start_q;
  logic            armed_q;

  logic            e_bit;
  logic            idx_zero;
  logic            m_is_one;

  assign e_bit    = e_q[idx_q];
  assign idx_zero = (idx_q == '0);
  assign m_is_one = (m_q == n'(1));

  assign R             = r_q;
  assign done          = done_q;
  assign mul.mul_x     = mul_x_q;
  assign mul.mul_y     = mul_y_q;
  assign mul.mul_m     = m_q;
  assign mul.mul_start = mul_start_q;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      b_q         <= '0;
      e_q         <= '0;
      m_q         <= '0;
      r_q         <= '0;
      done_q      <= 1'b0;
      mul_x_q     <= '0;
      mul_y_q     <= '0;
      mul_start_q <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            b_q     <= B;
            e_q     <= E;
            m_q     <= M;
            idx_q   <= IW'(n - 1);
            state_q <= SCAN;
          end
        end

        SCAN: begin
          if (e_bit) begin
            r_q     <= b_q;
            state_q <= NEXT;
          end else if (idx_zero) begin
            // E = 0: B^0 is 1, except that everything is 0 modulo 1
            r_q     <= m_is_one ? '0 : n'(1);
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            idx_q <= idx_q - 1'b1;
          end
        end

        NEXT: begin
          if (idx_zero) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            idx_q   <= idx_q - 1'b1;
            state_q <= SQR_ISSUE;
          end
        end

        SQR_ISSUE: begin
          mul_x_q     <= r_q;
          mul_y_q     <= r_q;
          mul_start_q <= 1'b1;
          armed_q     <= 1'b0;
          state_q     <= SQR_WAIT;
        end

        SQR_WAIT: begin
          // a done still high from the previous operation must be seen low first
          if (!armed_q) begin
            if (!mul.mul_done) armed_q <= 1'b1;
          end else if (mul.mul_done) begin
            r_q         <= mul.mul_p;
            mul_start_q <= 1'b0;
            state_q     <= e_bit ? MUL_ISSUE : NEXT;
          end
        end

        MUL_ISSUE: begin
          mul_x_q     <= r_q;
          mul_y_q     <= b_q;
          mul_start_q <= 1'b1;
          armed_q     <= 1'b0;
          state_q     <= MUL_WAIT;
        end

        MUL_WAIT: begin
          if (!armed_q) begin
            if (!mul.mul_done) armed_q <= 1'b1;
          end else if (mul.mul_done) begin
            r_q         <= mul.mul_p;
            mul_start_q <= 1'b0;
            state_q     <= NEXT;
          end
        end

        DONE: begin
          if (start) begin
            done_q  <= 1'b0;
            state_q <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_modular_exponentiator.sv
// Randomized self-checking bench for modular_exponentiator at n=8 with a
// behavioural start/done multiplier and a plain-arithmetic exponent model.
module tb_modular_exponentiator;
  localparam int N = 8;

  logic         clk;
  logic         n_reset;
  logic         start;
  logic [N-1:0] B, E, M;
  logic [N-1:0] R;
  logic         done;

  modular_exponentiator_if #(.N(N)) mif ();

  modular_exponentiator #(.n(N)) dut (
    .clk     (clk),
    .n_reset (n_reset),
    .start   (start),
    .B       (B),
    .E       (E),
    .M       (M),
    .R       (R),
    .done    (done),
    .mul     (mif.master)
  );

  int checks = 0;
  int failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // multiplier model state
  bit   stale_mode = 0;
  bit   busy = 0;
  bit   prev_start = 0;
  int   stale_left = 0;
  int   lat = 0;
  int   early_caps = 0;
  int   unstable = 0;
  logic [N-1:0] exp_p;
  logic [N-1:0] cur_x, cur_y, cur_m;
  logic [N-1:0] op_x[$];
  logic [N-1:0] op_y[$];

  initial begin
    mif.mul_p    = '0;
    mif.mul_done = 1'b1;
    forever begin
      @(negedge clk);
      if (!n_reset) begin
        busy = 0;
        stale_left = 0;
        mif.mul_done = 1'b1;
        prev_start = 0;
      end else begin
        if (busy && prev_start && !mif.mul_start) early_caps++;
        if (mif.mul_start && !prev_start) begin
          cur_x = mif.mul_x; cur_y = mif.mul_y; cur_m = mif.mul_m;
          op_x.push_back(cur_x);
          op_y.push_back(cur_y);
          exp_p = N'((int'(cur_x) * int'(cur_y)) % int'(cur_m));
          busy = 1;
          lat = $urandom_range(3, 20);
          if (stale_mode) begin
            stale_left = 5;
            mif.mul_done = 1'b1;
            mif.mul_p = 8'hA5;
          end else begin
            mif.mul_done = 1'b0;
          end
        end else begin
          if (mif.mul_start && prev_start &&
              (mif.mul_x !== cur_x || mif.mul_y !== cur_y || mif.mul_m !== cur_m))
            unstable++;
          if (busy) begin
            if (stale_left > 0) begin
              stale_left--;
              if (stale_left == 0) mif.mul_done = 1'b0;
            end else if (lat > 1) begin
              lat--;
            end else begin
              mif.mul_p = exp_p;
              mif.mul_done = 1'b1;
              busy = 0;
            end
          end
        end
        prev_start = mif.mul_start;
      end
    end
  end

  function automatic int ref_modexp(int b, int e, int m);
    int r = 1 % m;
    for (int k = 0; k < e; k++) r = (r * b) % m;
    return r;
  endfunction

  logic [N-1:0] ex_x[$];
  logic [N-1:0] ex_y[$];

  function automatic void gen_ops(int b, int e, int m);
    int top = -1;
    int r;
    ex_x.delete(); ex_y.delete();
    for (int k = 0; k < N; k++) if (((e >> k) & 1) == 1) top = k;
    if (top < 0) return;
    r = b;
    for (int k = top - 1; k >= 0; k--) begin
      ex_x.push_back(N'(r)); ex_y.push_back(N'(r));
      r = (r * r) % m;
      if (((e >> k) & 1) == 1) begin
        ex_x.push_back(N'(r)); ex_y.push_back(N'(b));
        r = (r * b) % m;
      end
    end
  endfunction

  int job_cycles;

  task automatic launch(input logic [N-1:0] b, input logic [N-1:0] e, input logic [N-1:0] m);
    op_x.delete(); op_y.delete();
    early_caps = 0; unstable = 0;
    @(negedge clk);
    B = b; E = e; M = m; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    job_cycles = 0;
    while (!done && job_cycles < 3000) begin
      @(negedge clk);
      job_cycles++;
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL %s_timeout: done=%0b after %0d cycles, required 1", name, done, job_cycles);
    end
  endtask

  task automatic release_done(input string name);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL %s_done_drop: done=%0b required 0", name, done);
    end
  endtask

  task automatic run_job(input string name, input logic [N-1:0] b, input logic [N-1:0] e,
                         input logic [N-1:0] m);
    int exp_r;
    exp_r = ref_modexp(int'(b), int'(e), int'(m));
    gen_ops(int'(b), int'(e), int'(m));
    launch(b, e, m);
    wait_done(name);
    checks++;
    if (R !== N'(exp_r)) begin
      failures++;
      $display("FAIL %s_result: R=%0d required %0d (B=%0d E=%0d M=%0d)", name, R, exp_r, b, e, m);
    end
    checks++;
    if (op_x.size() != ex_x.size()) begin
      failures++;
      $display("FAIL %s_op_count: ops=%0d required %0d", name, op_x.size(), ex_x.size());
    end else begin
      for (int k = 0; k < ex_x.size(); k++) begin
        checks++;
        if (op_x[k] !== ex_x[k] || op_y[k] !== ex_y[k]) begin
          failures++;
          $display("FAIL %s_op%0d: x/y=%0d/%0d required %0d/%0d", name, k, op_x[k], op_y[k],
                   ex_x[k], ex_y[k]);
        end
      end
    end
    checks++;
    if (early_caps != 0 || unstable != 0) begin
      failures++;
      $display("FAIL %s_protocol: early=%0d unstable=%0d required 0/0", name, early_caps, unstable);
    end
    release_done(name);
  endtask

  task automatic test_reset();
    checks++;
    if (R !== '0 || done !== 1'b0 || mif.mul_start !== 1'b0 || mif.mul_x !== '0 ||
        mif.mul_y !== '0 || mif.mul_m !== '0) begin
      failures++;
      $display("FAIL reset_state: R=%0d done=%0b start=%0b x=%0d y=%0d m=%0d required all 0",
               R, done, mif.mul_start, mif.mul_x, mif.mul_y, mif.mul_m);
    end
  endtask

  task automatic test_basic();
    run_job("basic", 8'd5, 8'd3, 8'd13);
    checks++;
    if (R !== 8'd8) begin
      failures++;
      $display("FAIL basic_const: R=%0d required 8", R);
    end
  endtask

  task automatic test_msb_only();
    run_job("msb_only", 8'd7, 8'h80, 8'd11);
    checks++;
    if (R !== 8'd9 || op_x.size() != 7) begin
      failures++;
      $display("FAIL msb_only_const: R=%0d ops=%0d required 9 and 7", R, op_x.size());
    end
  endtask

  task automatic test_all_ones();
    run_job("all_ones", 8'd2, 8'hFF, 8'd251);
    checks++;
    if (R !== 8'd32 || op_x.size() != 14) begin
      failures++;
      $display("FAIL all_ones_const: R=%0d ops=%0d required 32 and 14", R, op_x.size());
    end
  endtask

  task automatic test_zero_exp();
    logic [N-1:0] mods[2];
    logic [N-1:0] want[2];
    mods[0] = 8'd13; want[0] = 8'd1;
    mods[1] = 8'd1;  want[1] = 8'd0;
    for (int k = 0; k < 2; k++) begin
      launch(8'd0, 8'd0, mods[k]);
      wait_done("zero_exp");
      checks++;
      if (R !== want[k] || op_x.size() != 0 || job_cycles > N + 2) begin
        failures++;
        $display("FAIL zero_exp_m%0d: R=%0d ops=%0d cycles=%0d required %0d, 0, <=%0d",
                 mods[k], R, op_x.size(), job_cycles, want[k], N + 2);
      end
      release_done("zero_exp");
    end
  endtask

  task automatic test_stale_done();
    stale_mode = 1;
    run_job("stale", 8'd5, 8'd3, 8'd13);
    stale_mode = 0;
  endtask

  task automatic test_reset_mid_op();
    int guard = 0;
    launch(8'd2, 8'hFF, 8'd251);
    while (op_x.size() < 2 && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (op_x.size() < 2) begin
      failures++;
      $display("FAIL midop_reach: ops=%0d required 2", op_x.size());
    end
    @(negedge clk);
    n_reset = 1'b0;
    #1;
    checks++;
    if (R !== '0 || done !== 1'b0 || mif.mul_start !== 1'b0) begin
      failures++;
      $display("FAIL midop_reset: R=%0d done=%0b mul_start=%0b required 0/0/0",
               R, done, mif.mul_start);
    end
    @(negedge clk);
    n_reset = 1'b1;
    run_job("after_reset", 8'd5, 8'd3, 8'd13);
  endtask

  task automatic test_restart();
    launch(8'd5, 8'd3, 8'd13);
    wait_done("restart_pre");
    op_x.delete(); op_y.delete();
    @(negedge clk);
    B = 8'd3; E = 8'd4; M = 8'd7; start = 1'b1;
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL restart_drop: done=%0b required 0", done);
    end
    @(negedge clk);
    start = 1'b0;
    wait_done("restart");
    checks++;
    if (R !== 8'd4 || op_x.size() != 2) begin
      failures++;
      $display("FAIL restart_result: R=%0d ops=%0d required 4 and 2", R, op_x.size());
    end
    release_done("restart");
  endtask

  task automatic test_random();
    logic [N-1:0] m, b, e;
    for (int k = 0; k < 12; k++) begin
      m = N'($urandom_range(1, 255));
      b = N'($urandom % int'(m));
      e = N'($urandom_range(0, 255));
      run_job("random", b, e, m);
    end
  endtask

  initial begin
    n_reset = 1'b0;
    start = 1'b0;
    B = '0; E = '0; M = '0;
    repeat (3) @(negedge clk);
    test_reset();
    n_reset = 1'b1;
    test_basic();
    test_msb_only();
    test_all_ones();
    test_zero_exp();
    test_stale_done();
    test_reset_mid_op();
    test_restart();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
